// File: rtl/cordic_vector_if.sv
// cordic_vector_if: sample/result handshake bundle for the vectoring CORDIC.
//   in_x, in_y   signed input pair (I/Q)
//   in_valid     sample present           in_ready   engine can accept a sample
//   mag          magnitude times CORDIC gain (unsigned, BITS+1 bits)
//   phase        signed binary angle, full circle = 2^ANGLE_BITS
//   out_valid    result present           out_ready  consumer takes the result
// master = sample producer / result consumer, slave = the CORDIC engine.
interface cordic_vector_if #(
    parameter int BITS       = 20,
    parameter int ANGLE_BITS = 16
);
    logic signed [BITS-1:0]       in_x;
    logic signed [BITS-1:0]       in_y;
    logic                         in_valid;
    logic                         in_ready;
    logic        [BITS:0]         mag;
    logic signed [ANGLE_BITS-1:0] phase;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_x, in_y, in_valid, out_ready,
        input  in_ready, mag, phase, out_valid
    );

    modport slave (
        input  in_x, in_y, in_valid, out_ready,
        output in_ready, mag, phase, out_valid
    );
endinterface

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC. Takes one signed (x, y)
// pair, rotates it onto the positive x axis one micro-rotation per clock and
// reports the scaled magnitude (final x) and the accumulated angle (final z).
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset; aborts any computation in flight
//   bus    cordic_vector_if.slave (sample in, result out, valid/ready on both)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a sample; pre-rotation happens on accept
// ITER  | one micro-rotation per clock, counter runs 0..ITERS-1
// DONE  | out_valid=1, mag/phase held until out_ready
module cordic_vector #(
    parameter int BITS       = 20,
    parameter int ITERS      = 16,
    parameter int ANGLE_BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    cordic_vector_if.slave  bus
);
    localparam int XW = BITS + 2;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    // The arctangent table is held at 16-bit angle resolution and rescaled
    // for other ANGLE_BITS (rounded when narrowing, zero-filled when widening).
    localparam int          ATAN_UP  = (ANGLE_BITS >= 16) ? ANGLE_BITS - 16 : 0;
    localparam int          ATAN_DN  = (ANGLE_BITS < 16) ? 16 - ANGLE_BITS : 0;
    localparam logic [31:0] ATAN_RND = (32'd1 << ATAN_DN) >> 1;

    localparam logic [ANGLE_BITS-1:0] QUARTER = ANGLE_BITS'(1) << (ANGLE_BITS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [XW-1:0]   x_q, x_d;
    logic signed [XW-1:0]   y_q, y_d;
    logic [ANGLE_BITS-1:0]  z_q, z_d;
    logic [CW-1:0]          iter_q, iter_d;

    logic signed [XW-1:0]   x_in;
    logic signed [XW-1:0]   y_in;
    logic signed [XW-1:0]   x_sh;
    logic signed [XW-1:0]   y_sh;
    logic [ANGLE_BITS-1:0]  atan_i;

    function automatic logic [ANGLE_BITS-1:0] atan_lut(input int unsigned idx);
        logic [31:0] base;
        logic [31:0] scaled;
        case (idx)
            0:       base = 32'd8192;
            1:       base = 32'd4836;
            2:       base = 32'd2555;
            3:       base = 32'd1297;
            4:       base = 32'd651;
            5:       base = 32'd326;
            6:       base = 32'd163;
            7:       base = 32'd81;
            8:       base = 32'd41;
            9:       base = 32'd20;
            10:      base = 32'd10;
            11:      base = 32'd5;
            12:      base = 32'd3;
            13:      base = 32'd1;
            14:      base = 32'd1;
            default: base = 32'd0;
        endcase
        scaled = ((base << ATAN_UP) + ATAN_RND) >> ATAN_DN;
        return scaled[ANGLE_BITS-1:0];
    endfunction

    // Sign-extend before any negation so that -2^(BITS-1) negates cleanly.
    assign x_in   = {{2{bus.in_x[BITS-1]}}, bus.in_x};
    assign y_in   = {{2{bus.in_y[BITS-1]}}, bus.in_y};
    assign x_sh   = x_q >>> iter_q;
    assign y_sh   = y_q >>> iter_q;
    assign atan_i = atan_lut(32'(iter_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Fold the left half-plane into the right one so the
                    // micro-rotations only have to cover +-90 degrees.
                    if (!x_in[XW-1]) begin
                        x_d = x_in;
                        y_d = y_in;
                        z_d = '0;
                    end else if (!y_in[XW-1]) begin
                        x_d = y_in;
                        y_d = -x_in;
                        z_d = QUARTER;
                    end else begin
                        x_d = -y_in;
                        y_d = x_in;
                        z_d = -QUARTER;
                    end
                    iter_d  = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end
                iter_d = iter_q + CW'(1);
                if (iter_q == CW'(ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // x/y/z are frozen outside ITER, so the result can be driven straight
    // from the datapath registers; reset clears them, giving mag=phase=0.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.mag       = x_q[BITS:0];
    assign bus.phase     = z_q;
endmodule

// File: tb/tb_cordic_vector.sv
module tb_cordic_vector;
    localparam int BITS       = 20;
    localparam int ITERS      = 16;
    localparam int ANGLE_BITS = 16;
    localparam real PI        = 3.14159265358979323846;

    logic clk;
    logic reset;

    cordic_vector_if #(.BITS(BITS), .ANGLE_BITS(ANGLE_BITS)) bus ();

    cordic_vector #(.BITS(BITS), .ITERS(ITERS), .ANGLE_BITS(ANGLE_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    x;
        int    y;
        int    exp_phase;
        int    exp_mag;
        int    ptol;
        int    mtol;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;
    real  kgain;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int cdiff(input int a, input int b);
        int d;
        d = (a - b) & 32'h0000FFFF;
        if (d >= 32768) d = d - 65536;
        return d;
    endfunction

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: ideal polar conversion, magnitude scaled by the CORDIC gain.
    function automatic int ref_phase(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
        return rnd(a);
    endfunction

    function automatic int ref_mag(input int x, input int y);
        return rnd(kgain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
    endfunction

    task automatic send(input int x, input int y, output bit ok);
        int n;
        bus.in_x     = BITS'(x);
        bus.in_y     = BITS'(y);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok = bus.out_valid;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int lat;
        int m;
        int p;
        send(v.x, v.y, ok);
        check({v.name, "_accept"}, ok, int'(ok), 1);
        check({v.name, "_in_ready_low"}, !bus.in_ready, int'(bus.in_ready), 0);
        wait_out(lat, ok);
        check({v.name, "_latency"}, ok && lat == ITERS, lat, ITERS);
        m = int'(bus.mag);
        p = int'(bus.phase);
        check({v.name, "_phase"}, abs_i(cdiff(p, v.exp_phase)) <= v.ptol, p, v.exp_phase);
        check({v.name, "_mag"}, abs_i(m - v.exp_mag) <= v.mtol, m, v.exp_mag);
        take();
        check({v.name, "_release"}, !bus.out_valid && bus.in_ready,
              int'({bus.out_valid, bus.in_ready}), 1);
    endtask

    initial begin
        bit ok;
        bit flag;
        int lat;
        int m0;
        int p0;
        vec_t v;

        n_tests = 0;
        n_fail  = 0;
        kgain   = 1.0;
        for (int i = 0; i < ITERS; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", bus.in_ready == 1'b1, int'(bus.in_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", bus.out_valid == 1'b0, int'(bus.out_valid), 0);
        check("reset_mag", bus.mag == '0, int'(bus.mag), 0);
        check("reset_phase", bus.phase == '0, int'(bus.phase), 0);

        vecs.push_back('{"pos_x",   524287,       0,      0, 863375, 2, 8});
        vecs.push_back('{"pos_y",        0,  524287,  16384, 863375, 2, 8});
        vecs.push_back('{"neg_x",  -524288,       0, -32768, 863377, 2, 8});
        vecs.push_back('{"q3",     -300000, -300000, -24576, 698660, 2, 8});
        vecs.push_back('{"q4",      300000, -300000,  -8192, 698660, 2, 8});
        vecs.push_back('{"neg_y",        0, -524288, -16384, 863377, 2, 8});
        vecs.push_back('{"corner", -524288, -524288, -24576, 1221000, 2, 1200});
        for (int k = 0; k < 64; k++) begin
            real a;
            a = 2.0 * PI * real'(k) / 64.0;
            v.name      = $sformatf("sweep%0d", k);
            v.x         = rnd(400000.0 * $cos(a));
            v.y         = rnd(400000.0 * $sin(a));
            v.exp_phase = (k * 1024) & 16'hFFFF;
            v.exp_mag   = 658704;
            v.ptol      = 3;
            v.mtol      = 10;
            vecs.push_back(v);
        end
        for (int k = 0; k < 40; k++) begin
            int x;
            int y;
            x = 0;
            y = 0;
            for (int t = 0; t < 100; t++) begin
                x = int'($urandom_range(0, 1048575)) - 524288;
                y = int'($urandom_range(0, 1048575)) - 524288;
                if (ref_mag(x, y) > 100000) break;
            end
            v.name      = $sformatf("rand%0d", k);
            v.x         = x;
            v.y         = y;
            v.exp_phase = ref_phase(x, y);
            v.exp_mag   = ref_mag(x, y);
            v.ptol      = 4;
            v.mtol      = 12;
            vecs.push_back(v);
        end

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Backpressure: result held for 20 cycles, new samples ignored.
        send(300000, -300000, ok);
        wait_out(lat, ok);
        check("bp_out_valid", ok, int'(ok), 1);
        m0 = int'(bus.mag);
        p0 = int'(bus.phase);
        check("bp_phase", abs_i(cdiff(p0, -8192)) <= 2, p0, -8192);
        bus.in_x     = BITS'(12345);
        bus.in_y     = BITS'(-777);
        bus.in_valid = 1'b1;
        flag = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (int'(bus.mag) != m0 || int'(bus.phase) != p0 || bus.in_ready || !bus.out_valid)
                flag = 1'b0;
        end
        check("bp_stable", flag, int'(bus.mag), m0);
        bus.in_valid = 1'b0;
        take();
        check("bp_release", !bus.out_valid && bus.in_ready,
              int'({bus.out_valid, bus.in_ready}), 1);

        // Reset in the middle of ITER aborts the sample.
        send(200000, 100000, ok);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", bus.in_ready == 1'b1, int'(bus.in_ready), 1);
        check("abort_mag", bus.mag == '0, int'(bus.mag), 0);
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) flag = 1'b1;
        end
        check("abort_no_out", !flag, int'(flag), 0);
        send(0, 0, ok);
        wait_out(lat, ok);
        check("zero_latency", ok && lat == ITERS, lat, ITERS);
        check("zero_mag", bus.mag == '0, int'(bus.mag), 0);
        take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_vector.md
Name: cordic_vector

Overview:
- Iterative CORDIC engine in vectoring mode: the inverse of the team's rotation-mode sine/cosine oscillator.
- Accepts one signed (x, y) sample pair and returns its magnitude (scaled by the CORDIC gain) and its phase as a binary angle.
- Used to demodulate the oscillator's quadrature outputs, or any I/Q pair, back to amplitude/phase.
- One sample in flight at a time; valid/ready handshake on both sides.

Parameters:
- BITS, 20, width of signed input samples in_x/in_y.
- ITERS, 16, number of CORDIC micro-rotations; legal range 1..16.
- ANGLE_BITS, 16, width of the phase output; the full circle equals 2^ANGLE_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_x  in  BITS  signed x (cos/I) sample.
- in_y  in  BITS  signed y (sin/Q) sample.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- mag  out  BITS+1  unsigned magnitude times K (K≈1.64676).
- phase  out  ANGLE_BITS  signed binary angle: 0=0°, 2^(ANGLE_BITS-2)=+90°, -2^(ANGLE_BITS-1)=180°.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.

Behaviour:
- Reset (synchronous, active-high, clock clk) values: state IDLE, in_ready=1, out_valid=0, mag=0, phase=0, internal x/y/z and iteration counter cleared.
- Reset mid-operation aborts the computation; no result is emitted.
- State machine has three states: IDLE, ITER, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load the pre-rotated operands and go to ITER with i=0.
- Internal x and y are signed BITS+2 bits. Inputs are sign-extended before any negation, so -2^(BITS-1) is a legal input.
- Pre-rotation (same cycle as accept):
  - x>=0: (x,y,z) = (x, y, 0).
  - x<0 and y>=0: (x,y,z) = (y, -x, +2^(ANGLE_BITS-2)).
  - x<0 and y<0: (x,y,z) = (-y, x, -2^(ANGLE_BITS-2)).
- ITER, one micro-rotation per clock, all shifts arithmetic (>>>):
  - y>=0: x += y>>>i; y -= x>>>i (old x); z += atan_i.
  - y<0: x -= y>>>i; y += x>>>i (old x); z -= atan_i.
  - After iteration ITERS-1, go to DONE.
- atan_i is a constant table of round(atan(2^-i)·2^ANGLE_BITS/2π). For ANGLE_BITS=16: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- z is ANGLE_BITS wide and wraps modulo 2^ANGLE_BITS. No saturation.
- DONE:
  - out_valid=1; mag = final x (non-negative, bits BITS:0); phase = final z.
  - Outputs are held stable until out_valid&&out_ready.
  - On that handshake, out_valid drops and the state returns to IDLE (in_ready=1 the next cycle).
- Latency: out_valid rises ITERS clock edges after the accepting edge (16 for the defaults).
- Throughput: one sample per ITERS+2 cycles with out_ready held high.
- in_ready=0 in ITER and DONE; in_valid is ignored there and the inputs are not sampled.
- Zero input: mag=0; the phase value is deterministic but unspecified.

Test Plan:
- Reset, then in=(524287, 0) -> in_ready drops next cycle; out_valid exactly 16 cycles after accept; mag=863375±8; phase=0±2.
- in=(0, 524287) -> phase=16384±2, mag=863375±8. in=(-524288, 0) -> phase=-32768±2 (modulo 2^16), mag≈863377±8.
- in=(-300000, -300000) -> phase=-24576±2 (-135°), mag=698660±8. in=(300000, -300000) -> phase=-8192±2.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> mag/phase stable, in_ready=0, new in_valid ignored; out_ready=1 -> out_valid falls, in_ready=1 next cycle.
- Assert reset in the middle of ITER -> no out_valid, in_ready=1 after reset. The next sample (0,0) yields mag=0.
- Sweep 64 (x,y) pairs at 5.625° steps, amplitude 400000 -> every phase within ±3 LSB of round(angle·65536/360) mod 2^16; every mag within ±10 of 658704.
